flow_ctrl: RTL and testbench
============================

FLOW_CTRL -- requirements
Module: flow_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  pipeline clock.
REQ-002 SHALL have ports: rst  in  1  reset; one clock, reset synchronous and active-high.
REQ-003 SHALL have ports: ex_load_i  in  1  instruction in EX is a load.
REQ-004 SHALL have ports: ex_rd_adder_i  in  REG_ADDR_WIDTH  EX destination register.
REQ-005 SHALL have ports: id_rs1_adder_i, id_rs2_adder_i  in  REG_ADDR_WIDTH each  ID source registers.
REQ-006 SHALL have ports: id_rs1_used_i, id_rs2_used_i  in  1 each  source actually read.
REQ-007 SHALL have ports: jump_taken_i  in  1  EX resolved a taken branch/jump.
REQ-008 SHALL have ports: mc_start_i  in  1  multi-cycle op (div) starts in EX.
REQ-009 SHALL have ports: mc_done_i  in  1  multi-cycle op result valid this cycle.
REQ-010 SHALL have ports: halt_req_i  in  1  debug halt request, level.
REQ-011 SHALL have ports: flow_pc_o, flow_id_o, flow_ex_o, flow_mem_o  out  FLOW_WIDTH each  FLOW_WORK/FLOW_STOP/FLOW_REFRESH for PC, IF/ID, ID/EX, EX/MEM registers.
REQ-012 SHALL have ports: halt_ack_o  out  1  registered, core halted.
REQ-013 SHALL have ports: stall_cnt_o  out  32  stall cycle count (only with STALL_CNT_EN).

Function
REQ-014 SHALL implement FSM states RUN, MC_WAIT, DRAIN, HALT; flow outputs combinational from state and inputs.
REQ-015 SHALL define hazard = ex_load_i & ex_rd_adder_i!=0 & ((rd==rs1 & rs1_used) | (rd==rs2 & rs2_used)).
REQ-016 RUN priority 1, jump_taken_i: pc WORK, id REFRESH, ex REFRESH, mem WORK; stay RUN.
REQ-017 RUN priority 2, mc_start_i: pc STOP, id STOP, ex STOP, mem REFRESH; next MC_WAIT.
REQ-018 RUN priority 3, hazard: pc STOP, id STOP, ex REFRESH, mem WORK for exactly one cycle; stay RUN.
REQ-019 RUN priority 4, halt_req_i: pc STOP, id STOP, ex REFRESH, mem WORK; next DRAIN, drain counter=1.
REQ-020 RUN otherwise: all four outputs WORK.
REQ-021 MC_WAIT, mc_done_i=0: pc/id/ex STOP, mem REFRESH; jump_taken_i, hazard, halt_req_i ignored.
REQ-022 MC_WAIT, mc_done_i=1: all WORK; next RUN; pending halt_req_i evaluated from next cycle.
REQ-023 DRAIN: pc STOP, id STOP, ex REFRESH, mem WORK; after second DRAIN cycle (counter 1) next HALT.
REQ-024 DRAIN with jump_taken_i: pc WORK, id REFRESH, ex REFRESH, mem WORK; drain continues.
REQ-025 DRAIN with mc_start_i: REQ-017 outputs, next MC_WAIT, drain counter cleared; halt re-entered via RUN.
REQ-026 DRAIN with halt_req_i dropped: finish current cycle outputs, next RUN.
REQ-027 HALT: all four outputs STOP; halt_ack_o=1 from first HALT cycle; halt_req_i=0 -> next RUN, halt_ack_o=0 following cycle.
REQ-028 SHALL never emit WORK on flow_pc_o while flow_id_o is STOP.

Reset
REQ-029 rst=1 at clock edge: state RUN, drain counter 0, halt_ack_o 0, stall_cnt_o 0.
REQ-030 While rst=1: all flow outputs REFRESH regardless of state; reset mid-MC_WAIT/DRAIN/HALT aborts to RUN.

Configuration
REQ-031 Macro STALL_CNT_EN defined: stall_cnt_o exists, increments once per cycle with flow_pc_o==FLOW_STOP and state!=HALT, saturates at 32'hFFFF_FFFF.
REQ-032 STALL_CNT_EN undefined: stall_cnt_o port and counter absent; all other behaviour identical.

Verification
REQ-033 ex_load_i=1, ex_rd=5, id_rs1=5, rs1_used=1 -> one cycle pc/id STOP, ex REFRESH, mem WORK, then all WORK.
REQ-034 Same as REQ-033 with ex_rd=0 -> all WORK, no stall.
REQ-035 jump_taken_i=1 with hazard=1 simultaneously -> pc WORK, id/ex REFRESH (jump wins).
REQ-036 mc_start_i pulse, mc_done_i 6 cycles later -> 6 cycles pc/id/ex STOP, mem REFRESH, then all WORK; with STALL_CNT_EN stall_cnt_o=7.
REQ-037 halt_req_i=1 in RUN -> 2 DRAIN cycles, HALT all STOP, halt_ack_o=1 on 3rd edge; drop halt_req_i -> RUN, ack 0.
REQ-038 rst=1 one cycle during MC_WAIT -> flow outputs REFRESH that cycle, RUN next, halt_ack_o 0, stall_cnt_o 0.

Source files
------------

// File: rtl/flow_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : flow_ctrl
//  Description : Pipeline flow controller. Each cycle it tells the PC, IF/ID,
//                ID/EX and EX/MEM registers to WORK (advance), STOP (hold) or
//                REFRESH (load a bubble). It resolves taken jumps, load-use
//                hazards, multi-cycle (divide) operations and debug halt
//                requests.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            in   1               pipeline clock
//    rst            in   1               synchronous active-high reset
//    ex_load_i      in   1               instruction in EX is a load
//    ex_rd_adder_i  in   REG_ADDR_WIDTH  EX destination register
//    id_rs1_adder_i in   REG_ADDR_WIDTH  ID source register 1
//    id_rs2_adder_i in   REG_ADDR_WIDTH  ID source register 2
//    id_rs1_used_i  in   1               ID actually reads rs1
//    id_rs2_used_i  in   1               ID actually reads rs2
//    jump_taken_i   in   1               EX resolved a taken branch/jump
//    mc_start_i     in   1               multi-cycle op starts in EX
//    mc_done_i      in   1               multi-cycle result valid this cycle
//    halt_req_i     in   1               debug halt request (level)
//    flow_pc_o      out  FLOW_WIDTH      PC register control
//    flow_id_o      out  FLOW_WIDTH      IF/ID register control
//    flow_ex_o      out  FLOW_WIDTH      ID/EX register control
//    flow_mem_o     out  FLOW_WIDTH      EX/MEM register control
//    halt_ack_o     out  1               registered, core is halted
//    stall_cnt_o    out  32              stall cycle count (STALL_CNT_EN only)
//
//  Build option
//    STALL_CNT_EN : when defined, adds the saturating stall counter and the
//                   stall_cnt_o port.
//
//  Flow encoding : WORK = 0, STOP = 1, REFRESH = 2
// ============================================================================
module flow_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int FLOW_WIDTH     = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ex_load_i,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd_adder_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_adder_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_adder_i,
  input  logic                      id_rs1_used_i,
  input  logic                      id_rs2_used_i,
  input  logic                      jump_taken_i,
  input  logic                      mc_start_i,
  input  logic                      mc_done_i,
  input  logic                      halt_req_i,
  output logic [FLOW_WIDTH-1:0]     flow_pc_o,
  output logic [FLOW_WIDTH-1:0]     flow_id_o,
  output logic [FLOW_WIDTH-1:0]     flow_ex_o,
  output logic [FLOW_WIDTH-1:0]     flow_mem_o,
  output logic                      halt_ack_o
`ifdef STALL_CNT_EN
  ,
  output logic [31:0]               stall_cnt_o
`endif
);

  localparam logic [FLOW_WIDTH-1:0] FLOW_WORK    = FLOW_WIDTH'(0);
  localparam logic [FLOW_WIDTH-1:0] FLOW_STOP    = FLOW_WIDTH'(1);
  localparam logic [FLOW_WIDTH-1:0] FLOW_REFRESH = FLOW_WIDTH'(2);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MC_WAIT = 2'd1,
    DRAIN   = 2'd2,
    HALT    = 2'd3
  } state_e;

  state_e state_q, state_d;
  // Drain cycles still to go after the current one (loaded with 1 on entry).
  logic   drain_cnt_q, drain_cnt_d;
  logic   halt_ack_q;
  logic   w_hazard;

  // Load-use hazard: x0 is never a real dependency.
  assign w_hazard = ex_load_i && (ex_rd_adder_i != '0) &&
                    (((ex_rd_adder_i == id_rs1_adder_i) && id_rs1_used_i) ||
                     ((ex_rd_adder_i == id_rs2_adder_i) && id_rs2_used_i));

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    flow_pc_o   = FLOW_WORK;
    flow_id_o   = FLOW_WORK;
    flow_ex_o   = FLOW_WORK;
    flow_mem_o  = FLOW_WORK;

    case (state_q)
      RUN: begin
        if (jump_taken_i) begin
          flow_id_o = FLOW_REFRESH;
          flow_ex_o = FLOW_REFRESH;
        end else if (mc_start_i) begin
          flow_pc_o  = FLOW_STOP;
          flow_id_o  = FLOW_STOP;
          flow_ex_o  = FLOW_STOP;
          flow_mem_o = FLOW_REFRESH;
          state_d    = MC_WAIT;
        end else if (w_hazard || halt_req_i) begin
          // Hold fetch/decode and push a bubble into EX.
          flow_pc_o = FLOW_STOP;
          flow_id_o = FLOW_STOP;
          flow_ex_o = FLOW_REFRESH;
          if (!w_hazard) begin
            state_d     = DRAIN;
            drain_cnt_d = 1'b1;
          end
        end
      end

      MC_WAIT: begin
        if (mc_done_i) begin
          state_d = RUN;
        end else begin
          flow_pc_o  = FLOW_STOP;
          flow_id_o  = FLOW_STOP;
          flow_ex_o  = FLOW_STOP;
          flow_mem_o = FLOW_REFRESH;
        end
      end

      DRAIN: begin
        if (jump_taken_i) begin
          flow_id_o = FLOW_REFRESH;
          flow_ex_o = FLOW_REFRESH;
        end else if (mc_start_i) begin
          flow_pc_o  = FLOW_STOP;
          flow_id_o  = FLOW_STOP;
          flow_ex_o  = FLOW_STOP;
          flow_mem_o = FLOW_REFRESH;
        end else begin
          flow_pc_o = FLOW_STOP;
          flow_id_o = FLOW_STOP;
          flow_ex_o = FLOW_REFRESH;
        end

        // A divide started during drain must complete; the halt is then
        // re-requested from RUN.
        if (!jump_taken_i && mc_start_i) begin
          state_d     = MC_WAIT;
          drain_cnt_d = 1'b0;
        end else if (!halt_req_i) begin
          state_d     = RUN;
          drain_cnt_d = 1'b0;
        end else if (drain_cnt_q == 1'b0) begin
          state_d = HALT;
        end else begin
          drain_cnt_d = 1'b0;
        end
      end

      HALT: begin
        flow_pc_o  = FLOW_STOP;
        flow_id_o  = FLOW_STOP;
        flow_ex_o  = FLOW_STOP;
        flow_mem_o = FLOW_STOP;
        if (!halt_req_i) begin
          state_d = RUN;
        end
      end

      default: begin
        state_d = RUN;
      end
    endcase

    // Reset flushes every pipeline register regardless of state.
    if (rst) begin
      flow_pc_o  = FLOW_REFRESH;
      flow_id_o  = FLOW_REFRESH;
      flow_ex_o  = FLOW_REFRESH;
      flow_mem_o = FLOW_REFRESH;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      drain_cnt_q <= 1'b0;
      halt_ack_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      halt_ack_q  <= (state_d == HALT);
    end
  end

  assign halt_ack_o = halt_ack_q;

`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Cycles spent halted are deliberate, not stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if ((flow_pc_o == FLOW_STOP) && (state_q != HALT) &&
                 (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_flow_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_flow_ctrl
//  Description : Self-checking bench for flow_ctrl. A driver applies directed
//                and random stimulus, a reference model pushes the expected
//                per-cycle outputs into a scoreboard queue and an independent
//                monitor pops and compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_flow_ctrl;

  localparam int RAW = 5;
  localparam logic [1:0] F_WORK    = 2'd0;
  localparam logic [1:0] F_STOP    = 2'd1;
  localparam logic [1:0] F_REFRESH = 2'd2;

  // Per-cycle patterns, ordered {pc, id, ex, mem}.
  localparam logic [7:0] P_ALLWORK = {F_WORK, F_WORK, F_WORK, F_WORK};
  localparam logic [7:0] P_JUMP    = {F_WORK, F_REFRESH, F_REFRESH, F_WORK};
  localparam logic [7:0] P_MC      = {F_STOP, F_STOP, F_STOP, F_REFRESH};
  localparam logic [7:0] P_BUBBLE  = {F_STOP, F_STOP, F_REFRESH, F_WORK};
  localparam logic [7:0] P_ALLSTOP = {F_STOP, F_STOP, F_STOP, F_STOP};
  localparam logic [7:0] P_RST     = {F_REFRESH, F_REFRESH, F_REFRESH, F_REFRESH};

  localparam int M_RUN = 0, M_DIV = 1, M_DRAIN = 2, M_HALTED = 3;

  typedef struct packed {
    logic           rst;
    logic           load;
    logic [RAW-1:0] rd;
    logic [RAW-1:0] rs1;
    logic [RAW-1:0] rs2;
    logic           u1;
    logic           u2;
    logic           jump;
    logic           mcs;
    logic           mcd;
    logic           halt;
  } stim_t;

  typedef struct packed {
    logic [7:0]  pat;
    logic        ack;
    logic [31:0] stall;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           ex_load_i = 1'b0;
  logic [RAW-1:0] ex_rd_adder_i = '0;
  logic [RAW-1:0] id_rs1_adder_i = '0;
  logic [RAW-1:0] id_rs2_adder_i = '0;
  logic           id_rs1_used_i = 1'b0;
  logic           id_rs2_used_i = 1'b0;
  logic           jump_taken_i = 1'b0;
  logic           mc_start_i = 1'b0;
  logic           mc_done_i = 1'b0;
  logic           halt_req_i = 1'b0;
  logic [1:0]     flow_pc_o, flow_id_o, flow_ex_o, flow_mem_o;
  logic           halt_ack_o;
`ifdef STALL_CNT_EN
  logic [31:0]    stall_cnt_o;
`endif

  flow_ctrl #(.REG_ADDR_WIDTH(RAW), .FLOW_WIDTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_load_i      (ex_load_i),
    .ex_rd_adder_i  (ex_rd_adder_i),
    .id_rs1_adder_i (id_rs1_adder_i),
    .id_rs2_adder_i (id_rs2_adder_i),
    .id_rs1_used_i  (id_rs1_used_i),
    .id_rs2_used_i  (id_rs2_used_i),
    .jump_taken_i   (jump_taken_i),
    .mc_start_i     (mc_start_i),
    .mc_done_i      (mc_done_i),
    .halt_req_i     (halt_req_i),
    .flow_pc_o      (flow_pc_o),
    .flow_id_o      (flow_id_o),
    .flow_ex_o      (flow_ex_o),
    .flow_mem_o     (flow_mem_o),
    .halt_ack_o     (halt_ack_o)
`ifdef STALL_CNT_EN
    ,
    .stall_cnt_o    (stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  exp_t        sb_q[$];
  int          errors = 0;
  int          checks = 0;

  // Reference model state.
  int          m_mode  = M_RUN;
  int          m_left  = 0;      // drain cycles remaining, including current
  logic        m_ack   = 1'b0;
  logic [31:0] m_stall = '0;

  // Apply one cycle of stimulus, predict that cycle's outputs, then advance.
  task automatic step(input stim_t s);
    exp_t e;
    logic [7:0] pat;
    bit hz;
    int nxt;
    rst            = s.rst;
    ex_load_i      = s.load;
    ex_rd_adder_i  = s.rd;
    id_rs1_adder_i = s.rs1;
    id_rs2_adder_i = s.rs2;
    id_rs1_used_i  = s.u1;
    id_rs2_used_i  = s.u2;
    jump_taken_i   = s.jump;
    mc_start_i     = s.mcs;
    mc_done_i      = s.mcd;
    halt_req_i     = s.halt;

    hz  = s.load && (s.rd != 0) &&
          ((s.rd == s.rs1 && s.u1) || (s.rd == s.rs2 && s.u2));
    nxt = m_mode;
    pat = P_ALLWORK;
    if (s.rst) begin
      pat    = P_RST;
      nxt    = M_RUN;
      m_left = 0;
    end else if (m_mode == M_RUN) begin
      if (s.jump)      pat = P_JUMP;
      else if (s.mcs)  begin pat = P_MC; nxt = M_DIV; end
      else if (hz)     pat = P_BUBBLE;
      else if (s.halt) begin pat = P_BUBBLE; nxt = M_DRAIN; m_left = 2; end
    end else if (m_mode == M_DIV) begin
      if (s.mcd) nxt = M_RUN;
      else       pat = P_MC;
    end else if (m_mode == M_DRAIN) begin
      pat = s.jump ? P_JUMP : (s.mcs ? P_MC : P_BUBBLE);
      if (!s.jump && s.mcs) begin
        nxt = M_DIV; m_left = 0;
      end else if (!s.halt) begin
        nxt = M_RUN; m_left = 0;
      end else begin
        m_left = m_left - 1;
        if (m_left == 0) nxt = M_HALTED;
      end
    end else begin
      pat = P_ALLSTOP;
      if (!s.halt) nxt = M_RUN;
    end

    e.pat   = pat;
    e.ack   = m_ack;
    e.stall = m_stall;
    sb_q.push_back(e);

    if (s.rst) begin
      m_ack   = 1'b0;
      m_stall = '0;
    end else begin
      if (pat[7:6] == F_STOP && m_mode != M_HALTED && m_stall != 32'hFFFF_FFFF)
        m_stall = m_stall + 32'd1;
      m_ack = (nxt == M_HALTED);
    end
    m_mode = nxt;
    @(posedge clk);
    #1;
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin : monitor
    exp_t e;
    int cyc;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if ({flow_pc_o, flow_id_o, flow_ex_o, flow_mem_o} !== e.pat) begin
          errors++;
          $display("FAIL flow cyc=%0d got pc/id/ex/mem=%0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                   cyc, flow_pc_o, flow_id_o, flow_ex_o, flow_mem_o,
                   e.pat[7:6], e.pat[5:4], e.pat[3:2], e.pat[1:0]);
        end
        checks++;
        if (halt_ack_o !== e.ack) begin
          errors++;
          $display("FAIL halt_ack cyc=%0d got %0b want %0b", cyc, halt_ack_o, e.ack);
        end
        checks++;
        if (flow_pc_o == F_WORK && flow_id_o == F_STOP) begin
          errors++;
          $display("FAIL pc_work_id_stop cyc=%0d got pc=%0d id=%0d want not WORK/STOP",
                   cyc, flow_pc_o, flow_id_o);
        end
`ifdef STALL_CNT_EN
        checks++;
        if (stall_cnt_o !== e.stall) begin
          errors++;
          $display("FAIL stall_cnt cyc=%0d got %0d want %0d", cyc, stall_cnt_o, e.stall);
        end
`endif
        cyc++;
      end
    end
  end

  initial begin : driver
    stim_t s;
    logic  h;
    @(posedge clk);
    #1;
    // Reset state.
    s = '0; s.rst = 1'b1;
    step(s); step(s);
    s = '0; step(s);

    // Load-use hazard on rs1, then clear.
    s = '0; s.load = 1'b1; s.rd = 5'd5; s.rs1 = 5'd5; s.u1 = 1'b1;
    step(s);
    s = '0; step(s);
    // Same with rd = x0: no stall.
    s = '0; s.load = 1'b1; s.rd = 5'd0; s.rs1 = 5'd0; s.u1 = 1'b1;
    step(s);
    // Hazard on rs2 together with a taken jump: jump wins.
    s = '0; s.load = 1'b1; s.rd = 5'd7; s.rs2 = 5'd7; s.u2 = 1'b1; s.jump = 1'b1;
    step(s);

    // Divide: start, six waiting cycles, then done (from a fresh reset).
    s = '0; s.rst = 1'b1; step(s);
    s = '0; s.mcs = 1'b1; step(s);
    s = '0; s.jump = 1'b1; s.halt = 1'b0; step(s);
    s = '0; s.load = 1'b1; s.rd = 5'd3; s.rs1 = 5'd3; s.u1 = 1'b1; step(s);
    s = '0; repeat (4) step(s);
    s = '0; s.mcd = 1'b1; step(s);
    s = '0; step(s);

    // Halt: two drain cycles, halted, release.
    s = '0; s.halt = 1'b1; repeat (5) step(s);
    s = '0; step(s); step(s);

    // Jump during drain keeps draining.
    s = '0; s.halt = 1'b1; step(s);
    s.jump = 1'b1; step(s);
    s.jump = 1'b0; step(s); step(s);
    s = '0; step(s); step(s);

    // Divide started during drain, halt re-entered via RUN.
    s = '0; s.halt = 1'b1; step(s);
    s.mcs = 1'b1; step(s);
    s.mcs = 1'b0; step(s);
    s.mcd = 1'b1; step(s);
    s.mcd = 1'b0; repeat (4) step(s);
    s = '0; step(s); step(s);

    // Halt dropped mid-drain returns to RUN.
    s = '0; s.halt = 1'b1; step(s);
    s = '0; step(s); step(s);

    // Reset in the middle of a divide wait.
    s = '0; s.mcs = 1'b1; step(s);
    s = '0; step(s);
    s = '0; s.rst = 1'b1; step(s);
    s = '0; step(s); step(s);

    // Randomised traffic with a slowly toggling halt level.
    h = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 11) == 0) h = ~h;
      s.rst  = ($urandom_range(0, 99) < 2);
      s.load = 1'($urandom_range(0, 1));
      s.rd   = 5'($urandom_range(0, 3));
      s.rs1  = 5'($urandom_range(0, 3));
      s.rs2  = 5'($urandom_range(0, 3));
      s.u1   = 1'($urandom_range(0, 1));
      s.u2   = 1'($urandom_range(0, 1));
      s.jump = ($urandom_range(0, 7) == 0);
      s.mcs  = ($urandom_range(0, 9) == 0);
      s.mcd  = ($urandom_range(0, 3) == 0);
      s.halt = h;
      step(s);
    end

    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
